simon32_encrypt_core: RTL
=========================

Name: simon32_encrypt_core

Overview:
- Iterative SIMON 32/64 block-encryption engine, one round per clock.
- Sits directly downstream of the nibble/byte input collector. It consumes that stage's 32-bit `data`, 64-bit `key_out` and `done` strobe, and produces a 32-bit ciphertext with a one-cycle valid pulse.
- Round keys are expanded on the fly. No key RAM.

Parameters:
- ROUNDS, 32, number of rounds executed. Legal range is 2..32. Must be even when SIMON_UNROLL2_EN is defined. The value 32 gives standard SIMON32/64.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- load  input  1  start strobe, driven by the collector's `done`; only a rising edge is acted on
- data_in  input  32  plaintext; [31:16]=x (left word), [15:0]=y (right word)
- key_in  input  64  key; [63:48]=k3, [47:32]=k2, [31:16]=k1, [15:0]=k0
- cipher  output  32  ciphertext, same word layout as data_in
- valid  output  1  one-cycle pulse when cipher is updated
- busy  output  1  high from the capture edge until the cycle valid is high, inclusive

Behaviour:
- Reset (asynchronous): state=IDLE, cipher=0, valid=0, busy=0, load_q=0, round counter=0, x/y/key registers=0.
- Edge detect: load_q<=load every cycle. start = load & ~load_q.
  - The collector's two-cycle done therefore starts exactly one operation.
- State machine: IDLE -> RUN -> DONE -> IDLE.
  - IDLE: on start, capture x=data_in[31:16], y=data_in[15:0], kr0..kr3=key_in words k0..k3, rnd=0, busy<=1, go to RUN. Without start, hold.
  - RUN: each edge performs round rnd and increments rnd.
    - Round: x'=y ^ f(x) ^ kr0; y'=x; f(x)=(rol1(x) & rol8(x)) ^ rol2(x).
    - Key expansion: tmp=ror3(kr3) ^ kr1; tmp=tmp ^ ror1(tmp); new=kr0 ^ 16'hFFFC ^ {15'b0,z0[rnd]} ^ tmp; shift kr0<=kr1, kr1<=kr2, kr2<=kr3, kr3<=new.
    - On the edge completing round ROUNDS-1: cipher<={x',y'}, valid<=1, go to DONE.
  - DONE: valid=1 and busy=1 for this one cycle. Next edge: valid<=0, busy<=0, go to IDLE.
- z0 sequence: 62-bit constant 11111010001001010110000111001101111101000100101011000011100110. z0[0] is the leftmost bit. The index never wraps because ROUNDS<=32.
- Latency: valid is high in the cycle after the 32nd edge following the capture edge (ROUNDS=32).
- cipher holds its value until the next completion or reset.
- start while busy (RUN or DONE) is ignored and not queued. load_q still tracks load, so a level held across completion does not restart.
- load high while reset deasserts: load_q=0, so a start fires on the first edge after reset release.
- Reset mid-operation aborts immediately. All outputs return to reset values. No valid is produced for the aborted block.
- data_in and key_in are sampled only on the capture edge. They may change freely afterwards.

Optional Feature:
- Macro SIMON_UNROLL2_EN.
- When defined: two rounds and two key expansions are chained per edge (z0 indices rnd and rnd+1), and rnd advances by 2. Latency becomes ROUNDS/2 edges (16 for ROUNDS=32). Results are bit-identical.
- When undefined: one round per edge as specified above.

Decomposition:
- Package simon_pkg holds:
  - WORD_W=16
  - Z0 (62-bit constant)
  - KEY_C=16'hFFFC
  - MAX_ROUNDS=32
  - state enum {IDLE,RUN,DONE}
- Sub-module simon_round: purely combinational. Inputs: x, y, kr0..kr3, z bit. Outputs: x', y', next kr0..kr3.
  - Instantiated once, or twice in series under SIMON_UNROLL2_EN.

Test Plan:
- Standard vector. key_in=64'h1918_1110_0908_0100, data_in=32'h6565_6877, one load pulse -> after 32 edges valid=1 for one cycle, cipher=32'hC69B_E9BB.
- Collector-style strobe. load held high 2 cycles, then low -> exactly one valid pulse. busy is high 33 cycles.
- Busy rejection. Second load rising edge at round 10 with different data -> ignored. The single valid carries 32'hC69B_E9BB and busy drops once.
- Mid-op reset. Assert reset asynchronously during round 15 -> cipher=0, valid=0, busy=0 immediately. A new load of the standard vector then yields 32'hC69B_E9BB.
- Back-to-back operation. New load rising edge in the first IDLE cycle after valid -> accepted. The second result is correct and the first cipher is held until then.
- SIMON_UNROLL2_EN defined, standard vector -> valid after 16 edges, cipher=32'hC69B_E9BB.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared constants and helpers for the SIMON 32/64 encryption core.
// SIMON_UNROLL2_EN (optional) selects two rounds per clock in the core.
package simon_pkg;

    localparam int unsigned WORD_W     = 16;
    localparam int unsigned MAX_ROUNDS = 32;
    localparam logic [WORD_W-1:0] KEY_C = 16'hFFFC;

    // Index 0 is the leftmost bit of the published z0 sequence.
    localparam logic [0:61] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    function automatic logic z0_bit(input logic [5:0] idx);
        return Z0[idx];
    endfunction

endpackage

// File: rtl/simon_round.sv
// One combinational SIMON 32/64 round plus one step of the on-the-fly key schedule.
module simon_round
    import simon_pkg::*;
(
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] y,
    input  logic [WORD_W-1:0] kr0,
    input  logic [WORD_W-1:0] kr1,
    input  logic [WORD_W-1:0] kr2,
    input  logic [WORD_W-1:0] kr3,
    input  logic              z,
    output logic [WORD_W-1:0] x_next,
    output logic [WORD_W-1:0] y_next,
    output logic [WORD_W-1:0] kr0_next,
    output logic [WORD_W-1:0] kr1_next,
    output logic [WORD_W-1:0] kr2_next,
    output logic [WORD_W-1:0] kr3_next
);

    logic [WORD_W-1:0] f_x;
    logic [WORD_W-1:0] tmp_a;
    logic [WORD_W-1:0] tmp_b;

    assign f_x    = ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]};
    assign x_next = y ^ f_x ^ kr0;
    assign y_next = x;

    assign tmp_a = {kr3[2:0], kr3[15:3]} ^ kr1;
    assign tmp_b = tmp_a ^ {tmp_a[0], tmp_a[15:1]};

    assign kr0_next = kr1;
    assign kr1_next = kr2;
    assign kr2_next = kr3;
    assign kr3_next = kr0 ^ KEY_C ^ {15'b0, z} ^ tmp_b;

endmodule

// File: rtl/simon32_encrypt_core.sv
// Iterative SIMON 32/64 encryption core, key schedule expanded on the fly.
// Define SIMON_UNROLL2_EN to chain two rounds per clock (ROUNDS must then be even).
module simon32_encrypt_core
    import simon_pkg::*;
#(
    parameter int unsigned ROUNDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [63:0] key_in,
    output logic [31:0] cipher,
    output logic        valid,
    output logic        busy
);

    localparam int unsigned RND_W = 6;
`ifdef SIMON_UNROLL2_EN
    localparam int unsigned STEP = 2;
`else
    localparam int unsigned STEP = 1;
`endif
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - STEP);

    state_t            state_q, state_d;
    logic [RND_W-1:0]  rnd_q, rnd_d;
    logic [WORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [WORD_W-1:0] kr0_q, kr0_d, kr1_q, kr1_d, kr2_q, kr2_d, kr3_q, kr3_d;
    logic [31:0]       cipher_q, cipher_d;
    logic              valid_q, valid_d, busy_q, busy_d, load_q;
    logic              start;

    logic [WORD_W-1:0] x_nx, y_nx, kr0_nx, kr1_nx, kr2_nx, kr3_nx;

`ifdef SIMON_UNROLL2_EN
    logic [WORD_W-1:0] x_m, y_m, kr0_m, kr1_m, kr2_m, kr3_m;

    simon_round u_round0 (
        .x(x_q), .y(y_q), .kr0(kr0_q), .kr1(kr1_q), .kr2(kr2_q), .kr3(kr3_q),
        .z(z0_bit(rnd_q)),
        .x_next(x_m), .y_next(y_m),
        .kr0_next(kr0_m), .kr1_next(kr1_m), .kr2_next(kr2_m), .kr3_next(kr3_m)
    );

    simon_round u_round1 (
        .x(x_m), .y(y_m), .kr0(kr0_m), .kr1(kr1_m), .kr2(kr2_m), .kr3(kr3_m),
        .z(z0_bit(rnd_q + 6'd1)),
        .x_next(x_nx), .y_next(y_nx),
        .kr0_next(kr0_nx), .kr1_next(kr1_nx), .kr2_next(kr2_nx), .kr3_next(kr3_nx)
    );
`else
    simon_round u_round0 (
        .x(x_q), .y(y_q), .kr0(kr0_q), .kr1(kr1_q), .kr2(kr2_q), .kr3(kr3_q),
        .z(z0_bit(rnd_q)),
        .x_next(x_nx), .y_next(y_nx),
        .kr0_next(kr0_nx), .kr1_next(kr1_nx), .kr2_next(kr2_nx), .kr3_next(kr3_nx)
    );
`endif

    // Only a rising edge of load starts work, so a multi-cycle strobe runs once.
    assign start = load & ~load_q;

    always_comb begin
        state_d  = state_q;
        rnd_d    = rnd_q;
        x_d      = x_q;
        y_d      = y_q;
        kr0_d    = kr0_q;
        kr1_d    = kr1_q;
        kr2_d    = kr2_q;
        kr3_d    = kr3_q;
        cipher_d = cipher_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = data_in[31:16];
                    y_d     = data_in[15:0];
                    kr0_d   = key_in[15:0];
                    kr1_d   = key_in[31:16];
                    kr2_d   = key_in[47:32];
                    kr3_d   = key_in[63:48];
                    rnd_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d   = x_nx;
                y_d   = y_nx;
                kr0_d = kr0_nx;
                kr1_d = kr1_nx;
                kr2_d = kr2_nx;
                kr3_d = kr3_nx;
                rnd_d = rnd_q + RND_W'(STEP);
                if (rnd_q == LAST_RND) begin
                    cipher_d = {x_nx, y_nx};
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rnd_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            kr0_q    <= '0;
            kr1_q    <= '0;
            kr2_q    <= '0;
            kr3_q    <= '0;
            cipher_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rnd_q    <= rnd_d;
            x_q      <= x_d;
            y_q      <= y_d;
            kr0_q    <= kr0_d;
            kr1_q    <= kr1_d;
            kr2_q    <= kr2_d;
            kr3_q    <= kr3_d;
            cipher_q <= cipher_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            load_q   <= load;
        end
    end

    assign cipher = cipher_q;
    assign valid  = valid_q;
    assign busy   = busy_q;

endmodule
